// File: rtl/branch_predict_unit.sv
// Decode-stage branch resolver with a PC-indexed table of 2-bit saturating predictors.
// Optional statistics counters are built when BPU_STATS_EN is defined.
module branch_predict_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IDX_BITS  = 6,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_pc_f,
    output logic                 o_pred_taken_f,
    input  logic                 i_branch_valid_d,
    input  logic [2:0]           i_branch_op_d,
    input  logic [WIDTH-1:0]     i_rd1_d,
    input  logic [WIDTH-1:0]     i_rd2_d,
    input  logic [31:0]          i_pc_d,
    input  logic                 i_pred_taken_d,
    input  logic                 i_stall_d,
    input  logic                 i_flush_d,
    output logic                 o_condition_d,
    output logic                 o_resolve_valid_e,
    output logic                 o_resolve_taken_e,
    output logic                 o_mispredict_e
`ifdef BPU_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] o_branch_cnt,
    output logic [CNT_WIDTH-1:0] o_mispred_cnt
`endif
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [IDX_BITS-1:0]     w_idx_f;
    logic [IDX_BITS-1:0]     w_idx_d;
    logic                    w_accept;
    logic                    w_train;
    logic [1:0]              w_ctr_cur;
    logic [1:0]              w_ctr_next;
    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH-1:0] w_b;
    logic                    w_unused_pc;

    logic [1:0] r_pht [DEPTH];
    logic       r_resolve_valid;
    logic       r_resolve_taken;
    logic       r_pred;

    assign w_idx_f     = i_pc_f[IDX_BITS+1:2];
    assign w_idx_d     = i_pc_d[IDX_BITS+1:2];
    assign w_unused_pc = ^{i_pc_f[31:IDX_BITS+2], i_pc_f[1:0],
                           i_pc_d[31:IDX_BITS+2], i_pc_d[1:0]};

    // Read is the registered entry, so a same-cycle update is not bypassed.
    assign o_pred_taken_f = r_pht[w_idx_f][1];

    assign w_a = i_rd1_d;
    assign w_b = i_rd2_d;

    always_comb begin
        o_condition_d = 1'b0;
        case (i_branch_op_d)
            3'd0:    o_condition_d = (w_a == w_b);
            3'd1:    o_condition_d = (w_a > 0);
            3'd2:    o_condition_d = (w_a >= 0);
            3'd3:    o_condition_d = (w_a < 0);
            3'd4:    o_condition_d = (w_a <= 0);
            3'd5:    o_condition_d = (w_a != w_b);
            3'd6:    o_condition_d = 1'b1;
            default: o_condition_d = 1'b0;
        endcase
    end

    assign w_accept = i_branch_valid_d & ~i_flush_d & ~i_stall_d;
    assign w_train  = w_accept & (i_branch_op_d <= 3'd5);

    assign w_ctr_cur = r_pht[w_idx_d];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (o_condition_d) begin
            if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_pht[i] <= CTR_INIT;
        end else if (w_train) begin
            r_pht[w_idx_d] <= w_ctr_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resolve_valid <= 1'b0;
            r_resolve_taken <= 1'b0;
            r_pred          <= 1'b0;
        end else if (w_accept) begin
            r_resolve_valid <= 1'b1;
            r_resolve_taken <= o_condition_d;
            r_pred          <= i_pred_taken_d;
        end else if (!i_stall_d) begin
            r_resolve_valid <= 1'b0;
        end
    end

    assign o_resolve_valid_e = r_resolve_valid;
    assign o_resolve_taken_e = r_resolve_taken;
    assign o_mispredict_e    = r_resolve_valid & (r_resolve_taken != r_pred);

`ifdef BPU_STATS_EN
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispred_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_accept && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
            if (o_mispredict_e && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`else
    localparam int unsigned unused_cnt_width = CNT_WIDTH;
`endif

endmodule
